// File: rtl/fifo_param_pkg.sv
// Shared sizing constants and the per-cycle operation encoding for the
// parameterised synchronous FIFO.
package fifo_param_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 3;

  function automatic int depth_of(input int addr_size);
    return 1 << addr_size;
  endfunction

  function automatic int count_w_of(input int addr_size);
    return addr_size + 1;
  endfunction

  localparam int DEPTH_DEF   = depth_of(ADDR_SIZE_DEF);
  localparam int COUNT_W_DEF = count_w_of(ADDR_SIZE_DEF);

  // {read accepted, write accepted}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer-facing bus of fifo_param: requests, thresholds and status.
interface fifo_param_if
  import fifo_param_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
);

  logic                   write;
  logic                   read;
  logic [DATA_SIZE-1:0]   data_in_push;
  logic [ADDR_SIZE:0]     th_high;
  logic [ADDR_SIZE:0]     th_low;
  logic                   error_clear;

  logic [DATA_SIZE-1:0]   data_out_pop;
  logic                   data_out_valid;
  logic [ADDR_SIZE:0]     fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   fifo_pause;
  logic                   fifo_error;

  modport master (
    output write, read, data_in_push, th_high, th_low, error_clear,
    input  data_out_pop, data_out_valid, fifo_count, fifo_empty, fifo_full,
           almost_full, almost_empty, fifo_pause, fifo_error
  );

  modport slave (
    input  write, read, data_in_push, th_high, th_low, error_clear,
    output data_out_pop, data_out_valid, fifo_count, fifo_empty, fifo_full,
           almost_full, almost_empty, fifo_pause, fifo_error
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_SIZE storage: one write port, one registered read port.
// Neither the array nor the read register is reset.
module fifo_mem
  import fifo_param_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data_p1
);

  localparam int DEPTH = depth_of(ADDR_SIZE);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // A same-address read and write returns the old word, which is what a
  // simultaneous push/pop on a full FIFO needs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_p1 <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Single-clock parameterised FIFO: pointers, occupancy, threshold flags and
// a sticky overflow/underflow error around a fifo_mem storage array.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fifo_param_if.slave  bus
);

  localparam int                 DEPTH     = depth_of(ADDR_SIZE);
  localparam int                 COUNT_W   = count_w_of(ADDR_SIZE);
  localparam logic [COUNT_W-1:0] DEPTH_CNT = COUNT_W'(DEPTH);

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [COUNT_W-1:0]   count;
  logic                 err_q;
  logic                 vld_p1;
  logic                 rd_seen;
  logic [DATA_SIZE-1:0] rd_data_p1;

  logic                 full;
  logic                 empty;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 err_set;
  fifo_op_e             op;

  always_comb begin
    full    = (count == DEPTH_CNT);
    empty   = (count == '0);
    rd_acc  = bus.read && !empty;
    wr_acc  = bus.write && (!full || rd_acc);
    err_set = (bus.write && full && !rd_acc) || (bus.read && empty);
    op      = fifo_op_e'({rd_acc, wr_acc});
  end

  fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk        (clk),
    .wr_en      (wr_acc),
    .wr_addr    (wr_ptr),
    .wr_data    (bus.data_in_push),
    .rd_en      (rd_acc),
    .rd_addr    (rd_ptr),
    .rd_data_p1 (rd_data_p1)
  );

  // Stage p0 -> p1: pointers, occupancy, error and pop-valid registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_q   <= 1'b0;
      vld_p1  <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      end
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + ADDR_SIZE'(1);
        rd_seen <= 1'b1;
      end
      unique case (op)
        OP_PUSH: count <= count + COUNT_W'(1);
        OP_POP:  count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
      if (err_set) begin
        err_q <= 1'b1;
      end else if (bus.error_clear) begin
        err_q <= 1'b0;
      end
      vld_p1 <= rd_acc;
    end
  end

  // The storage read register is unreset, so the popped word is masked to
  // zero until the first pop after reset; afterwards it simply holds.
  assign bus.data_out_pop   = rd_seen ? rd_data_p1 : '0;
  assign bus.data_out_valid = vld_p1;
  assign bus.fifo_count     = count;
  assign bus.fifo_empty     = empty;
  assign bus.fifo_full      = full;
  assign bus.almost_full    = (count >= bus.th_high);
  assign bus.almost_empty   = (count <= bus.th_low);
  assign bus.fifo_pause     = (count >= bus.th_high) || full;
  assign bus.fifo_error     = err_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed plus randomized bench for fifo_param against a queue-based model.
module tb_fifo_param;
  import fifo_param_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fifo_param_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

  fifo_param #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_pop;
  bit            m_vld;
  bit            m_err;
  int            th_h;
  int            th_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int cnt;
    cnt = q.size();
    chk({ph, ".pop"},   bus.data_out_pop,   m_pop);
    chk({ph, ".vld"},   bus.data_out_valid, m_vld);
    chk({ph, ".count"}, bus.fifo_count,     cnt);
    chk({ph, ".empty"}, bus.fifo_empty,     cnt == 0);
    chk({ph, ".full"},  bus.fifo_full,      cnt == DEPTH);
    chk({ph, ".afull"}, bus.almost_full,    cnt >= th_h);
    chk({ph, ".aempty"},bus.almost_empty,   cnt <= th_l);
    chk({ph, ".pause"}, bus.fifo_pause,     (cnt >= th_h) || (cnt == DEPTH));
    chk({ph, ".error"}, bus.fifo_error,     m_err);
  endtask

  task automatic set_th(input int hi, input int lo);
    th_h = hi;
    th_l = lo;
    bus.th_high = 4'(hi);
    bus.th_low  = 4'(lo);
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(input string ph, input bit w, input bit r,
                      input logic [DW-1:0] d, input bit ec);
    bit full, empty, racc, wacc, eset;
    bus.write        = w;
    bus.read         = r;
    bus.data_in_push = d;
    bus.error_clear  = ec;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    racc  = r && !empty;
    wacc  = w && (!full || racc);
    eset  = (w && full && !racc) || (r && empty);
    m_vld = racc;
    if (racc) m_pop = q.pop_front();
    if (wacc) q.push_back(d);
    if (eset)    m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  // Asynchronous reset pulse placed well clear of any clock edge.
  task automatic pulse_reset(input string ph);
    bus.write = 1'b0;
    bus.read  = 1'b0;
    bus.error_clear = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    m_pop = '0;
    m_vld = 1'b0;
    m_err = 1'b0;
    check_all(ph);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    bus.write = 1'b0;
    bus.read  = 1'b0;
    bus.data_in_push = '0;
    bus.error_clear  = 1'b0;
    set_th(6, 2);
    m_pop = '0;
    m_vld = 1'b0;
    m_err = 1'b0;

    #3;
    check_all("in_reset");
    #9;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step("fill", 1'b1, 1'b0, 8'(8'h03 + i), 1'b0);
      chk("fill.count_abs", bus.fifo_count, i + 1);
    end
    chk("fill.full_abs", bus.fifo_full, 1);

    step("ovf", 1'b1, 1'b0, 8'h0B, 1'b0);
    chk("ovf.err_abs", bus.fifo_error, 1);
    step("ovf_hold", 1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain.data_abs", bus.data_out_pop, 8'h03 + i);
    end
    step("idle_hold", 1'b0, 1'b0, 8'h00, 1'b0);

    step("clr", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr.err_abs", bus.fifo_error, 0);
    step("udf", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf.err_abs", bus.fifo_error, 1);
    step("set_beats_clr", 1'b0, 1'b1, 8'h00, 1'b1);
    step("clr2", 1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 4; i++) step("rw_full", 1'b1, 1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      step("drain2", 1'b0, 1'b1, 8'h00, 1'b0);
      if (i >= 4) chk("drain2.data_abs", bus.data_out_pop, 8'h20 + i - 4);
    end

    for (int i = 0; i < 5; i++) step("burst", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    pulse_reset("mid_rst");
    chk("mid_rst.count_abs", bus.fifo_count, 0);
    step("post_rst_w", 1'b1, 1'b0, 8'h55, 1'b0);
    step("post_rst_r", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst.data_abs", bus.data_out_pop, 8'h55);

    step("sweep_w", 1'b1, 1'b0, 8'h61, 1'b0);
    step("sweep_w", 1'b1, 1'b0, 8'h62, 1'b0);
    set_th(6, 0); #1; chk("sweep.tl0", bus.almost_empty, 0);
    set_th(6, 2); #1; chk("sweep.tl2", bus.almost_empty, 1);
    set_th(6, 9); #1; chk("sweep.tl9", bus.almost_empty, 1);
    set_th(0, 2); #1; chk("th_high0", bus.almost_full, 1);
    set_th(6, 2);
    #1;

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 31) == 0) set_th($urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        step("rnd", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
             8'($urandom), ($urandom_range(0, 7) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
